// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU store path: store-type codes, FSM states and byte-enable masks.
package lsu_pkg;

  localparam logic [2:0] ST_SB = 3'd0;
  localparam logic [2:0] ST_SH = 3'd1;
  localparam logic [2:0] ST_SW = 3'd2;

  localparam logic [3:0] MASK_SB = 4'b0001;
  localparam logic [3:0] MASK_SH = 4'b0011;
  localparam logic [3:0] MASK_SW = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Illegal codes map to an empty mask so they can never enable a lane.
  function automatic logic [3:0] base_mask(input logic [2:0] sel);
    case (sel)
      ST_SB:   base_mask = MASK_SB;
      ST_SH:   base_mask = MASK_SH;
      ST_SW:   base_mask = MASK_SW;
      default: base_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel);
    sel_legal = (sel == ST_SB) || (sel == ST_SH) || (sel == ST_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane shifter: places right-justified store data and its byte mask
// onto a 64-bit (two-word) window starting at the byte offset.
module store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [63:0] data_out,
  output logic [7:0]  mask_out
);

  logic [3:0] base;

  assign base     = base_mask(sel);
  assign data_out = {32'd0, data} << {offset, 3'b000};
  assign mask_out = {4'd0, base} << offset;

endmodule

// File: rtl/lsu_store_ctrl.sv
// Store controller: aligns SB/SH/SW stores onto a word-wide write port, splitting a
// store that crosses a word boundary into two beats when STORE_MISALIGN_EN is defined.
module lsu_store_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_req,
  input  logic [2:0]  st_select,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bmask,
  input  logic        mem_ack
);

  state_t      state;
  logic [63:0] al_data;
  logic [7:0]  al_mask;
  logic        split;
  logic        legal;
  logic        accept;

  store_align u_align (
    .sel      (st_select),
    .offset   (st_addr[1:0]),
    .data     (st_data),
    .data_out (al_data),
    .mask_out (al_mask)
  );

  assign split    = |al_mask[7:4];
  assign st_ready = (state == IDLE);
  assign accept   = st_req && st_ready;

`ifdef STORE_MISALIGN_EN
  // Upper half of the captured request, replayed as the second beat.
  logic [31:0] hi_data;
  logic [3:0]  hi_mask;
  logic        is_split;

  assign legal = sel_legal(st_select);
`else
  logic unused_hi;

  assign legal     = sel_legal(st_select) && !split;
  assign unused_hi = ^al_data[63:32];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_bmask <= 4'd0;
`ifdef STORE_MISALIGN_EN
      hi_data   <= 32'd0;
      hi_mask   <= 4'd0;
      is_split  <= 1'b0;
`endif
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= al_data[31:0];
              mem_bmask <= al_mask[3:0];
`ifdef STORE_MISALIGN_EN
              hi_data   <= al_data[63:32];
              hi_mask   <= al_mask[7:4];
              is_split  <= split;
`endif
            end else begin
              st_err <= 1'b1;
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
`ifdef STORE_MISALIGN_EN
            if (is_split) begin
              state     <= BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= hi_data;
              mem_bmask <= hi_mask;
            end else begin
              state     <= IDLE;
              st_done   <= 1'b1;
              mem_req   <= 1'b0;
              mem_addr  <= 32'd0;
              mem_wdata <= 32'd0;
              mem_bmask <= 4'd0;
            end
`else
            state     <= IDLE;
            st_done   <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_bmask <= 4'd0;
`endif
          end
        end
        BEAT1: begin
`ifdef STORE_MISALIGN_EN
          if (mem_ack) begin
            state     <= IDLE;
            st_done   <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_bmask <= 4'd0;
          end
`else
          state     <= IDLE;
          mem_req   <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_bmask <= 4'd0;
`endif
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_store_ctrl.sv
// Randomized bench for lsu_store_ctrl against a byte-lane reference model; honours STORE_MISALIGN_EN.
module tb_lsu_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_req;
  logic [2:0]  st_select;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_ack;

  int pass_cnt = 0;
  int chk_cnt  = 0;

`ifdef STORE_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  lsu_store_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_req    (st_req),
    .st_select (st_select),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bmask (mem_bmask),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: expected beats of a store, from byte positions and sizes.
  bit               m_legal;
  int               m_nbeats;
  logic [31:0]      m_addr[2];
  logic [31:0]      m_data[2];
  logic [3:0]       m_mask[2];

  task automatic model(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
    int          off;
    int          nbytes;
    longint unsigned wide;
    int          mask8;
    off    = int'(addr % 4);
    nbytes = (sel == 3'd0) ? 1 : (sel == 3'd1) ? 2 : (sel == 3'd2) ? 4 : 0;
    wide   = longint'(data) * (64'd1 << (8 * off));
    mask8  = ((1 << nbytes) - 1) << off;
    m_legal  = (nbytes != 0) && (MIS || mask8 < 16);
    m_nbeats = (mask8 >= 16) ? 2 : 1;
    m_addr[0] = addr - 32'(off);
    m_addr[1] = m_addr[0] + 32'd4;
    m_data[0] = wide[31:0];
    m_data[1] = wide[63:32];
    m_mask[0] = 4'(mask8 % 16);
    m_mask[1] = 4'(mask8 / 16);
  endtask

  // Runs one store; w0/w1 are the idle-ack cycles before acking beat 0/1.
  task automatic do_store(input string nm, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input int w0, input int w1);
    int w;
    model(sel, addr, data);
    @(negedge clk);
    check({nm, ".ready"}, st_ready, 1'b1);
    st_req = 1'b1; st_select = sel; st_addr = addr; st_data = data;
    @(negedge clk);
    st_req = 1'b0;
    st_select = 3'($urandom); st_addr = $urandom; st_data = $urandom;
    if (!m_legal) begin
      check({nm, ".err"}, st_err, 1'b1);
      check({nm, ".noreq"}, mem_req, 1'b0);
      @(negedge clk);
      check({nm, ".err_clr"}, st_err, 1'b0);
      check({nm, ".noreq2"}, mem_req, 1'b0);
      return;
    end
    check({nm, ".noerr"}, st_err, 1'b0);
    for (int b = 0; b < m_nbeats; b++) begin
      w = (b == 0) ? w0 : w1;
      for (int k = 0; k <= w; k++) begin
        check($sformatf("%s.b%0d.req", nm, b), mem_req, 1'b1);
        check($sformatf("%s.b%0d.addr", nm, b), mem_addr, m_addr[b]);
        check($sformatf("%s.b%0d.wdata", nm, b), mem_wdata, m_data[b]);
        check($sformatf("%s.b%0d.bmask", nm, b), mem_bmask, m_mask[b]);
        check($sformatf("%s.b%0d.nodone", nm, b), st_done, 1'b0);
        mem_ack = (k == w);
        @(negedge clk);
      end
      mem_ack = 1'b0;
    end
    check({nm, ".done"}, st_done, 1'b1);
    check({nm, ".ready_back"}, st_ready, 1'b1);
    check({nm, ".idle_bus"}, {mem_req, mem_addr, mem_wdata, mem_bmask}, 69'd0);
    @(negedge clk);
    check({nm, ".done_clr"}, st_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; st_req = 1'b0; st_select = 3'd0; st_addr = 32'd0; st_data = 32'd0; mem_ack = 1'b0;
    #12;
    check("rst.bus", {mem_req, mem_addr, mem_wdata, mem_bmask}, 69'd0);
    check("rst.pulses", {st_done, st_err}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", st_ready, 1'b1);

    // Directed cases from the stated examples.
    do_store("sw_aligned", 3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    check("sw_aligned.model", m_data[0], 32'hDEADBEEF);
    do_store("sb_off3", 3'd0, 32'h203, 32'h000000A5, 1, 0);
    check("sb_off3.model", {m_addr[0], m_data[0], m_mask[0]}, {32'h200, 32'hA5000000, 4'b1000});
    do_store("sw_split", 3'd2, 32'h302, 32'h11223344, 0, 1);
    do_store("sh_3ff", 3'd1, 32'h3FF, 32'h0000BEEF, 3, 0);
    do_store("illegal5", 3'd5, 32'h40, 32'h12345678, 0, 0);
    do_store("sw_addr1", 3'd2, 32'h1, 32'hCAFEF00D, 0, 0);
    do_store("wrap", 3'd2, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, 2);

    // Randomized stores, with stray acks while idle.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  sel;
      logic [31:0] addr;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        check("idle_ack.noreq", mem_req, 1'b0);
        check("idle_ack.nodone", st_done, 1'b0);
      end
      sel  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      addr = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      do_store($sformatf("rnd%0d", i), sel, addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a transaction.
    @(negedge clk);
    st_req = 1'b1; st_select = 3'd2; st_addr = MIS ? 32'h302 : 32'h300; st_data = 32'h11223344;
    @(negedge clk);
    st_req = 1'b0;
    if (MIS) begin
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("mid.beat1_addr", mem_addr, 32'h304);
    end
    check("mid.req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid.rst_bus", {mem_req, mem_addr, mem_wdata, mem_bmask}, 69'd0);
    check("mid.rst_done", st_done, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.ready", st_ready, 1'b1);
    check("mid.nodone", st_done, 1'b0);
    @(negedge clk);
    check("mid.nodone2", st_done, 1'b0);
    check("mid.noreq", mem_req, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
